shared_chi_serial_dup: RTL and testbench

SHARED_CHI_SERIAL_DUP -- requirements
Module: shared_chi_serial_dup

---
 rtl/shared_chi_pkg.sv | 24 ++
 rtl/shared_toffoli_bit.sv | 17 +
 rtl/shared_chi_serial_dup.sv | 141 ++++++++++++++
 tb/tb_shared_chi_serial_dup.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/shared_chi_pkg.sv
// Shared definitions for the serial two-share chi unit: FSM states,
// index-width helper and the legal-width check.
package shared_chi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        OUT   = 2'd3
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // chi needs an odd width to be a permutation; the serial datapath is sized for 3..9
    function automatic bit w_legal(input int w);
        return (w >= 3) && (w <= 9) && ((w % 2) == 1);
    endfunction

endpackage

// File: rtl/shared_toffoli_bit.sv
// One bit of the two-share chi: y = a ^ (~b & c) split across shares.
// The cross-share product is folded in first so the shares never recombine.
module shared_toffoli_bit (
    input  logic a0,
    input  logic b0,
    input  logic c0,
    input  logic a1,
    input  logic b1,
    input  logic c1,
    output logic y0,
    output logic y1
);

    assign y0 = (a0 ^ (~b0 & c1)) ^ (~b0 & c0);
    assign y1 = (a1 ^ (b1 & c0)) ^ (b1 & c1);

endmodule

// File: rtl/shared_chi_serial_dup.sv
// Bit-serial masked chi with an optional duplicated datapath; the copies
// are compared before release and a mismatch suppresses the result.
module shared_chi_serial_dup
    import shared_chi_pkg::*;
#(
    parameter int W         = 5,
    parameter int REDUNDANT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x0_in,
    input  logic [W-1:0] x1_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y0_out,
    output logic [W-1:0] y1_out,
    output logic         fault_out,
    input  logic         fault_clear
);

    localparam int IW = clog2(W);
    localparam logic [IW-1:0] LAST = IW'(W - 1);

    if (!w_legal(W)) begin : g_bad_w
        $error("shared_chi_serial_dup: W must be odd and within 3..9");
    end

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx1;
    logic [IW-1:0] idx2;
    logic [W-1:0]  x0_r;
    logic [W-1:0]  x1_r;
    logic [W-1:0]  c0_y0;
    logic [W-1:0]  c0_y1;
    logic [W-1:0]  c1_y0;
    logic [W-1:0]  c1_y1;
    logic          fault;
    logic          accept;
    logic          mismatch;
    logic          t0_y0;
    logic          t0_y1;
    logic          t1_y0;
    logic          t1_y1;

    assign idx1 = (idx == LAST) ? '0 : idx + 1'b1;
    assign idx2 = (idx1 == LAST) ? '0 : idx1 + 1'b1;

    shared_toffoli_bit u_copy0 (
        .a0(x0_r[idx]), .b0(x0_r[idx1]), .c0(x0_r[idx2]),
        .a1(x1_r[idx]), .b1(x1_r[idx1]), .c1(x1_r[idx2]),
        .y0(t0_y0),     .y1(t0_y1)
    );

    if (REDUNDANT != 0) begin : g_dup
        shared_toffoli_bit u_copy1 (
            .a0(x0_r[idx]), .b0(x0_r[idx1]), .c0(x0_r[idx2]),
            .a1(x1_r[idx]), .b1(x1_r[idx1]), .c1(x1_r[idx2]),
            .y0(t1_y0),     .y1(t1_y1)
        );
    end else begin : g_single
        assign t1_y0 = 1'b0;
        assign t1_y1 = 1'b0;
    end

    // rst_n gates in_ready so nothing is offered while reset is held
    assign in_ready  = rst_n && (state == IDLE) && !fault;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign y0_out    = c0_y0;
    assign y1_out    = c0_y1;
    assign fault_out = (REDUNDANT != 0) ? fault : 1'b0;
    assign mismatch  = (c0_y0 != c1_y0) || (c0_y1 != c1_y1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (idx == LAST) state_next = CHECK;
            CHECK:   state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            x0_r  <= '0;
            x1_r  <= '0;
            c0_y0 <= '0;
            c0_y1 <= '0;
            c1_y0 <= '0;
            c1_y1 <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // a pending clear wins over a simultaneous request
                    if (fault && fault_clear) begin
                        fault <= 1'b0;
                    end else if (accept) begin
                        x0_r  <= x0_in;
                        x1_r  <= x1_in;
                        idx   <= '0;
                        c0_y0 <= '0;
                        c0_y1 <= '0;
                        c1_y0 <= '0;
                        c1_y1 <= '0;
                    end
                end
                CALC: begin
                    c0_y0[idx] <= t0_y0;
                    c0_y1[idx] <= t0_y1;
                    if (REDUNDANT != 0) begin
                        c1_y0[idx] <= t1_y0;
                        c1_y1[idx] <= t1_y1;
                    end
                    idx <= idx + 1'b1;
                end
                CHECK: begin
                    if ((REDUNDANT != 0) && mismatch) begin
                        fault <= 1'b1;
                        c0_y0 <= '0;
                        c0_y1 <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_chi_serial_dup.sv
// Directed bench for shared_chi_serial_dup: vector table on a W=5 duplicated
// unit, plus W=3 and non-redundant instances for the corner sequences.
module tb_shared_chi_serial_dup;

    logic clk;
    logic rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, fault_out, fault_clear;
    logic [4:0] x0_in, x1_in, y0_out, y1_out;

    logic       w3_in_valid, w3_in_ready, w3_out_valid, w3_out_ready, w3_fault_out, w3_fault_clear;
    logic [2:0] w3_x0_in, w3_x1_in, w3_y0_out, w3_y1_out;

    logic       nr_in_valid, nr_in_ready, nr_out_valid, nr_out_ready, nr_fault_out, nr_fault_clear;
    logic [4:0] nr_x0_in, nr_x1_in, nr_y0_out, nr_y1_out;

    int checks;
    int errors;

    typedef struct {
        logic [4:0] x0;
        logic [4:0] x1;
        logic [4:0] exp_y;
        int         stall;
    } vec_t;

    vec_t       vecs[5];
    logic [4:0] flip_v;

    shared_chi_serial_dup #(.W(5), .REDUNDANT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .x0_in(x0_in), .x1_in(x1_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0_out(y0_out), .y1_out(y1_out),
        .fault_out(fault_out), .fault_clear(fault_clear)
    );

    shared_chi_serial_dup #(.W(3), .REDUNDANT(1)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w3_in_valid), .in_ready(w3_in_ready),
        .x0_in(w3_x0_in), .x1_in(w3_x1_in),
        .out_valid(w3_out_valid), .out_ready(w3_out_ready),
        .y0_out(w3_y0_out), .y1_out(w3_y1_out),
        .fault_out(w3_fault_out), .fault_clear(w3_fault_clear)
    );

    shared_chi_serial_dup #(.W(5), .REDUNDANT(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(nr_in_valid), .in_ready(nr_in_ready),
        .x0_in(nr_x0_in), .x1_in(nr_x1_in),
        .out_valid(nr_out_valid), .out_ready(nr_out_ready),
        .y0_out(nr_y0_out), .y1_out(nr_y1_out),
        .fault_out(nr_fault_out), .fault_clear(nr_fault_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Share-0 / share-1 model written straight from the masked chi equations
    function automatic logic [4:0] share0(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        for (int i = 0; i < 5; i++)
            r[i] = a[i] ^ (~a[(i+1)%5] & b[(i+2)%5]) ^ (~a[(i+1)%5] & a[(i+2)%5]);
        return r;
    endfunction

    function automatic logic [4:0] share1(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] r;
        for (int i = 0; i < 5; i++)
            r[i] = b[i] ^ (b[(i+1)%5] & b[(i+2)%5]) ^ (b[(i+1)%5] & a[(i+2)%5]);
        return r;
    endfunction

    task automatic run_main(input logic [4:0] x0, input logic [4:0] x1,
                            input logic [4:0] exp_y, input int stall, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, " in_ready"}, in_ready, 1);
        x0_in = x0; x1_in = x1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
        chk({tag, " latency"}, n, 6);
        chk({tag, " chi"}, y0_out ^ y1_out, exp_y);
        chk({tag, " share0"}, y0_out, share0(x0, x1));
        chk({tag, " fault"}, fault_out, 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk({tag, " stall out_valid"}, out_valid, 1);
            chk({tag, " stall chi"}, y0_out ^ y1_out, exp_y);
            chk({tag, " stall share1"}, y1_out, share1(x0, x1));
            chk({tag, " stall in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " drained"}, out_valid, 0);
        chk({tag, " idle"}, in_ready, 1);
    endtask

    task automatic run_w3(input logic [2:0] x0, input logic [2:0] x1,
                          input logic [2:0] exp_y, input string tag);
        int n;
        chk({tag, " in_ready"}, w3_in_ready, 1);
        w3_x0_in = x0; w3_x1_in = x1; w3_in_valid = 1'b1;
        @(posedge clk); #1;
        w3_in_valid = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!w3_out_valid && n < 20);
        chk({tag, " latency"}, n, 4);
        chk({tag, " chi"}, w3_y0_out ^ w3_y1_out, exp_y);
        chk({tag, " fault"}, w3_fault_out, 0);
        w3_out_ready = 1'b1;
        @(posedge clk); #1;
        w3_out_ready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; fault_clear = 0; x0_in = '0; x1_in = '0;
        w3_in_valid = 0; w3_out_ready = 0; w3_fault_clear = 0; w3_x0_in = '0; w3_x1_in = '0;
        nr_in_valid = 0; nr_out_ready = 0; nr_fault_clear = 0; nr_x0_in = '0; nr_x1_in = '0;

        vecs[0] = '{5'b10110, 5'b10111, 5'b01001, 0};
        vecs[1] = '{5'b10101, 5'b10101, 5'b00000, 0};
        vecs[2] = '{5'b11111, 5'b00000, 5'b11111, 0};
        vecs[3] = '{5'b01100, 5'b01111, 5'b01011, 3};
        vecs[4] = '{5'b11001, 5'b01101, 5'b10001, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset y0", y0_out, 0);
        chk("reset y1", y1_out, 0);
        chk("reset fault", fault_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release in_ready", in_ready, 1);

        for (int v = 0; v < 5; v++)
            run_main(vecs[v].x0, vecs[v].x1, vecs[v].exp_y, vecs[v].stall, $sformatf("vec%0d", v));

        run_w3(3'b011, 3'b000, 3'b001, "w3 a");
        run_w3(3'b101, 3'b010, 3'b111, "w3 b");

        // Copy-1 corruption in the last CALC cycle, held through CHECK
        @(posedge clk); #1;
        x0_in = 5'b10110; x1_in = 5'b10111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flip_v = share0(5'b10110, 5'b10111) ^ 5'b00001;
        force dut.c1_y0 = flip_v;
        repeat (2) begin @(posedge clk); #1; end
        release dut.c1_y0;
        chk("flt out_valid", out_valid, 1);
        chk("flt fault", fault_out, 1);
        chk("flt y0 zero", y0_out, 0);
        chk("flt y1 zero", y1_out, 0);
        chk("flt in_ready busy", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("flt sticky", fault_out, 1);
        chk("flt in_ready idle", in_ready, 0);
        in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("flt no accept", out_valid, 0);
        chk("flt still blocked", in_ready, 0);
        fault_clear = 1'b1;
        @(posedge clk); #1;
        fault_clear = 1'b0; in_valid = 1'b0;
        chk("clear fault", fault_out, 0);
        chk("clear not accepted", in_ready, 1);
        @(posedge clk); #1;
        chk("clear stays idle", out_valid, 0);

        // Non-redundant variant: same corruption on the delivered register
        nr_x0_in = 5'b10110; nr_x1_in = 5'b10111; nr_in_valid = 1'b1;
        chk("nr in_ready", nr_in_ready, 1);
        @(posedge clk); #1;
        nr_in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        flip_v = share0(5'b10110, 5'b10111) ^ 5'b00001;
        force dut0.c0_y0 = flip_v;
        repeat (2) begin @(posedge clk); #1; end
        release dut0.c0_y0;
        chk("nr out_valid", nr_out_valid, 1);
        chk("nr fault", nr_fault_out, 0);
        chk("nr chi corrupted", nr_y0_out ^ nr_y1_out, 5'b01000);
        chk("nr share1", nr_y1_out, share1(5'b10110, 5'b10111));
        nr_out_ready = 1'b1;
        @(posedge clk); #1;
        nr_out_ready = 1'b0;

        // Asynchronous reset at idx=2
        x0_in = 5'b11001; x1_in = 5'b01101; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst in_ready", in_ready, 0);
        chk("arst out_valid", out_valid, 0);
        chk("arst y0", y0_out, 0);
        chk("arst y1", y1_out, 0);
        chk("arst fault", fault_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst release in_ready", in_ready, 1);
        run_main(5'b01100, 5'b01111, 5'b01011, 0, "post reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
